multiplier_datapath: RTL and testbench
======================================

// Module: multiplier_datapath
// PURPOSE
//  Register/arithmetic datapath for the 8-bit signed add-shift multiplier.
//  Sits directly downstream of the multiplier control FSM and consumes its Clr_ld/Add/Sub/Shift strobes.
//  Holds the sign-extension bit X, accumulator A, and multiplier/product-low register B.
//  Returns M = B[0] to the control FSM; the 16-bit signed product is {A,B} after 8 add/shift steps.
// PARAMETERS
//  WIDTH  8  operand width; A, B and S are WIDTH bits, adder is WIDTH+1 bits
// PORTS
//  Clk     in   1      clock, all state updates on rising edge
//  Reset   in   1      asynchronous, active-high reset
//  Clr_ld  in   1      clear A/X, load B from S
//  Add     in   1      {X,A} <= sext(A) + sext(S)
//  Sub     in   1      {X,A} <= sext(A) - sext(S)
//  Shift   in   1      arithmetic right shift of {X,A,B}
//  S       in   WIDTH  multiplicand / load value (switches), two's complement
//  Xval    out  1      X register (sign-extension bit)
//  Aval    out  WIDTH  A register (product high byte)
//  Bval    out  WIDTH  B register (product low byte)
//  M       out  1      B[0], combinational, to control FSM
// BEHAVIOUR
//  - Reset (async, any time incl. mid-multiply): X=0, A=0, B=0 immediately; M=0.
//  - All ops are single-cycle and take effect on the edge where the strobe is high; outputs are the registers.
//  - Priority when strobes overlap: Clr_ld > Sub > Add > Shift; only the highest-priority op executes.
//  - No strobe high: all registers hold.
//  - Clr_ld: A<=0, X<=0, B<=S.
//  - Add: 9-bit sum R = {A[W-1],A} + {S[W-1],S}; X<=R[W], A<=R[W-1:0]; B unchanged.
//  - Sub: R = {A[W-1],A} + ~{S[W-1],S} + 1 (9-bit ripple adder, carry-in 1); X<=R[W], A<=R[W-1:0].
//  - Carry out of bit W is discarded; the 9-bit result never overflows for 8-bit signed inputs.
//  - Shift: X<=X; A<={X,A[W-1:1]}; B<={A[0],B[W-1:1]} (17-bit ASR of {X,A,B}).
//  - M tracks B[0] combinationally; valid the cycle after any B update.
//  - Adder: a single WIDTH+1 ripple of full adders shared by Add and Sub (S inverted, carry-in=1 for Sub).
//  - S is sampled only on Clr_ld/Add/Sub edges; S changes at other times have no effect.
//  - Datapath holds no step counter and does not check op sequencing; the control FSM owns both.
// TESTING
//  1. Reset mid-shift, then Clr_ld with S=0x07 -> X=0,A=0x00,B=0x07,M=1.
//  2. From (1): Add with S=0xFD -> X=1,A=0xFD,B=0x07; then Shift -> X=1,A=0xFE,B=0x83,M=1.
//  3. A=0x00: Sub with S=0x80 -> X=0,A=0x80; Sub with A=0x05,S=0x03 -> X=0,A=0x02.
//  4. Full sequence driven per FSM (B=0x07, S=0xFD, add/sub per M, 8 shifts) -> {A,B}=0xFFEB (-21);
//     repeat with B=0x80, S=0x80 -> {A,B}=0x4000 (+16384).
//  5. Clr_ld and Add high together, S=0x11 -> load only: A=0x00,B=0x11; Add+Shift together -> add only, no shift.
//  6. Async Reset asserted between edges with registers nonzero -> all outputs 0 before next Clk edge.

Source files
------------

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - register/arithmetic datapath for the signed add-shift multiplier
//
// Purpose:
//   Holds the sign-extension bit X, the accumulator A (product high byte) and
//   the multiplier/product-low register B. It executes one operation per clock,
//   driven by strobes from the multiplier control FSM. After 8 add/shift steps,
//   the signed 2*WIDTH-bit product is {A,B}.
//
// Ports:
//   Clk     in   1      clock; all state updates on the rising edge
//   Reset   in   1      asynchronous, active-high reset
//   Clr_ld  in   1      clear A/X, load B from S
//   Add     in   1      {X,A} <= sext(A) + sext(S)
//   Sub     in   1      {X,A} <= sext(A) - sext(S)
//   Shift   in   1      arithmetic right shift of {X,A,B}
//   S       in   WIDTH  multiplicand / load value, two's complement
//   Xval    out  1      X register
//   Aval    out  WIDTH  A register
//   Bval    out  WIDTH  B register
//   M       out  1      B[0], combinational, to the control FSM

module multiplier_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_ld,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Shift,
  input  logic [WIDTH-1:0] S,
  output logic             Xval,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             M
);

  logic             x_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // One WIDTH+1 bit ripple adder serves both Add and Sub. For Sub, the
  // sign-extended S is inverted and the carry-in is forced to 1. Sub is used
  // directly as the select, so the adder follows the Sub > Add priority when
  // both strobes are high.
  logic [WIDTH:0] op_a;
  logic [WIDTH:0] op_b;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] carry;

  assign op_a     = {a_q[WIDTH-1], a_q};
  assign op_b     = Sub ? ~{S[WIDTH-1], S} : {S[WIDTH-1], S};
  assign carry[0] = Sub;

  genvar i;
  generate
    for (i = 0; i <= WIDTH; i++) begin : g_fa
      assign sum[i] = op_a[i] ^ op_b[i] ^ carry[i];
      // The carry out of the top bit is discarded. Because both operands
      // are sign-extended, the 9-bit result cannot overflow.
      if (i < WIDTH) begin : g_carry
        assign carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
      end
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else if (Clr_ld) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= S;
    end else if (Sub || Add) begin
      x_q <= sum[WIDTH];
      a_q <= sum[WIDTH-1:0];
    end else if (Shift) begin
      // Arithmetic right shift of {X,A,B}. X replicates into A's MSB, and
      // A's LSB moves into B's MSB.
      a_q <= {x_q, a_q[WIDTH-1:1]};
      b_q <= {a_q[0], b_q[WIDTH-1:1]};
    end
  end

  assign Xval = x_q;
  assign Aval = a_q;
  assign Bval = b_q;
  assign M    = b_q[0];

endmodule

// File: tb/tb_multiplier_datapath.sv
// tb/tb_multiplier_datapath.sv - self-checking bench for multiplier_datapath

module tb_multiplier_datapath;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Clr_ld = 1'b0;
  logic       Add = 1'b0;
  logic       Sub = 1'b0;
  logic       Shift = 1'b0;
  logic [7:0] S = 8'h00;
  logic       Xval;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       M;

  int total = 0;
  int bad = 0;

  logic       mx;
  logic [7:0] ma;
  logic [7:0] mb;

  multiplier_datapath #(.WIDTH(8)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clr_ld (Clr_ld),
    .Add    (Add),
    .Sub    (Sub),
    .Shift  (Shift),
    .S      (S),
    .Xval   (Xval),
    .Aval   (Aval),
    .Bval   (Bval),
    .M      (M)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".X"}, {31'd0, Xval}, {31'd0, mx});
    check({tag, ".A"}, {24'd0, Aval}, {24'd0, ma});
    check({tag, ".B"}, {24'd0, Bval}, {24'd0, mb});
    check({tag, ".M"}, {31'd0, M}, {31'd0, mb[0]});
  endtask

  // Reference model: applies the highest-priority strobe using signed
  // integer arithmetic and a 17-bit arithmetic shift.
  task automatic model_op(input logic c, input logic a, input logic s, input logic sh,
                          input logic [7:0] sv);
    int r;
    logic signed [16:0] v;
    if (c) begin
      mx = 1'b0; ma = 8'h00; mb = sv;
    end else if (s) begin
      r = int'($signed(ma)) - int'($signed(sv));
      mx = r[8]; ma = r[7:0];
    end else if (a) begin
      r = int'($signed(ma)) + int'($signed(sv));
      mx = r[8]; ma = r[7:0];
    end else if (sh) begin
      v = {mx, ma, mb};
      v = v >>> 1;
      mx = v[16]; ma = v[15:8]; mb = v[7:0];
    end
  endtask

  // Drives strobes shortly after an edge, lets the next rising edge apply
  // them, and then samples the outputs 1 time unit later.
  task automatic step(input logic c, input logic a, input logic s, input logic sh,
                      input logic [7:0] sv);
    Clr_ld = c; Add = a; Sub = s; Shift = sh; S = sv;
    @(posedge Clk);
    #1;
    model_op(c, a, s, sh, sv);
    Clr_ld = 1'b0; Add = 1'b0; Sub = 1'b0; Shift = 1'b0;
    S = 8'($urandom);
  endtask

  task automatic async_reset();
    #2 Reset = 1'b1;
    #1;
    mx = 1'b0; ma = 8'h00; mb = 8'h00;
    check_state("async_rst");
    Reset = 1'b0;
  endtask

  // Runs the control-FSM sequence: add (or subtract on the last step) when
  // M is set, then shift, for 8 steps. The result is compared with the
  // true signed product.
  task automatic multiply(input logic [7:0] mplier, input logic [7:0] mcand, input string tag);
    int prod;
    step(1'b1, 1'b0, 1'b0, 1'b0, mplier);
    for (int k = 0; k < 8; k++) begin
      if (mb[0]) begin
        if (k == 7) step(1'b0, 1'b0, 1'b1, 1'b0, mcand);
        else        step(1'b0, 1'b1, 1'b0, 1'b0, mcand);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
    end
    prod = int'($signed(mplier)) * int'($signed(mcand));
    check({tag, ".prod"}, {16'd0, Aval, Bval}, {16'd0, prod[15:0]});
  endtask

  initial begin
    mx = 1'b0; ma = 8'h00; mb = 8'h00;
    #12;
    check_state("reset");
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Test 1: reset during a shift, then load 0x07.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    Shift = 1'b1;
    async_reset();
    Shift = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    check("t1.B", {24'd0, Bval}, 32'h07);
    check("t1.M", {31'd0, M}, 32'd1);

    // Test 2: add 0xFD, then shift.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFD);
    check("t2.XA", {23'd0, Xval, Aval}, 32'h1FD);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("t2.XAB", {15'd0, Xval, Aval, Bval}, 32'h1FE83);
    check_state("t2");

    // Test 3: subtraction edge cases.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    check("t3.sub80", {23'd0, Xval, Aval}, 32'h080);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
    check("t3.sub3", {23'd0, Xval, Aval}, 32'h002);

    // Test 4: full multiplies.
    multiply(8'h07, 8'hFD, "t4a");
    check("t4a.val", {16'd0, Aval, Bval}, 32'hFFEB);
    multiply(8'h80, 8'h80, "t4b");
    check("t4b.val", {16'd0, Aval, Bval}, 32'h4000);

    // Test 5: overlapping strobes.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
    check("t5.ld", {16'd0, Aval, Bval}, 32'h0011);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
    check("t5.add_only", {15'd0, Xval, Aval, Bval}, 32'h02211);

    // Test 6: async reset between edges with registers nonzero.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    async_reset();

    // Random strobes and operands, including the occasional async reset.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] st;
      st = 4'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
      end else begin
        step(st[0], st[1], st[2], st[3], 8'($urandom));
        check_state("rand");
      end
    end

    // Random full multiplies.
    for (int n = 0; n < 30; n++) begin
      multiply(8'($urandom), 8'($urandom), "rmul");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
